// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared constants and types for the dual-port data memory.
//   AW / DW / DEPTH : default address width, data width and word count
//   dmem_state_t    : clear-sequencer state encoding
//   dword_t         : one data word
// ----------------------------------------------------------------------------
package dmem_pkg;

   localparam int AW    = 9;
   localparam int DW    = 16;
   localparam int DEPTH = 512;

   typedef enum logic {CLEAR, RUN} dmem_state_t;

   typedef logic [DW-1:0] dword_t;

endpackage

// File: rtl/dual_port_dmem_if.sv
// ----------------------------------------------------------------------------
// dual_port_dmem_if
// DM request/response bundle between the two execution pipes and the memory.
//   p0_/p1_DM_maddr     : word address per pipe
//   p0_/p1_DM_wdata     : write data per pipe
//   p0_/p1_DM_write_mem : write strobe per pipe
//   p0_/p1_DM_rdata     : registered read data per pipe
//   DM_ready            : memory cleared and accepting writes
//   DM_wcollide         : one-cycle pulse after a same-address double write
// Modports: master = CPU side, slave = memory side.
// ----------------------------------------------------------------------------
interface dual_port_dmem_if #(
   parameter int AW = dmem_pkg::AW,
   parameter int DW = dmem_pkg::DW
);

   logic [AW-1:0] p0_DM_maddr;
   logic [DW-1:0] p0_DM_wdata;
   logic          p0_DM_write_mem;
   logic [DW-1:0] p0_DM_rdata;

   logic [AW-1:0] p1_DM_maddr;
   logic [DW-1:0] p1_DM_wdata;
   logic          p1_DM_write_mem;
   logic [DW-1:0] p1_DM_rdata;

   logic          DM_ready;
   logic          DM_wcollide;

   modport master (
      output p0_DM_maddr, p0_DM_wdata, p0_DM_write_mem,
      output p1_DM_maddr, p1_DM_wdata, p1_DM_write_mem,
      input  p0_DM_rdata, p1_DM_rdata, DM_ready, DM_wcollide
   );

   modport slave (
      input  p0_DM_maddr, p0_DM_wdata, p0_DM_write_mem,
      input  p1_DM_maddr, p1_DM_wdata, p1_DM_write_mem,
      output p0_DM_rdata, p1_DM_rdata, DM_ready, DM_wcollide
   );

endinterface

// File: rtl/dmem_clear_seq.sv
// ----------------------------------------------------------------------------
// dmem_clear_seq
// After reset, walks every address once so the array starts at zero, then
// hands the memory over to the pipes.
//   clk, rst   : clock, async active-high reset
//   clear_we   : write zero to clear_addr this cycle
//   clear_addr : address being cleared
//   ready      : clear finished, pipes own the array
//
//   state | meaning
//   ------+-------------------------------------------------
//   CLEAR | zeroing mem[clear_addr], one word per cycle
//   RUN   | clear done, ports read/write freely
// ----------------------------------------------------------------------------
module dmem_clear_seq
   import dmem_pkg::*;
#(
   parameter int AW    = dmem_pkg::AW,
   parameter int DEPTH = dmem_pkg::DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   output logic          clear_we,
   output logic [AW-1:0] clear_addr,
   output logic          ready
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   dmem_state_t state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= CLEAR;
         clear_addr <= '0;
         clear_we   <= 1'b1;
         ready      <= 1'b0;
      end else if (state == CLEAR) begin
         clear_addr <= clear_addr + 1'b1;
         if (clear_addr == LAST_ADDR) begin
            state      <= RUN;
            clear_we   <= 1'b0;
            ready      <= 1'b1;
            clear_addr <= '0;
         end
      end
   end

endmodule

// File: rtl/dual_port_dmem.sv
// ----------------------------------------------------------------------------
// dual_port_dmem
// Dual-port data memory serving pipes p0 and p1. Synchronous 1-cycle read,
// write at the rising edge, p1 wins a same-address double write. The array
// is zeroed by dmem_clear_seq after every reset before writes are accepted.
//   clk, rst : clock, async active-high reset
//   dm       : dual_port_dmem_if.slave (addresses, write data/strobes,
//              registered read data, DM_ready, DM_wcollide)
// Build option:
//   DMEM_BYPASS_EN defined   -> write-first: a read of an address written in
//                               the same cycle returns the new data (p1's if
//                               both ports write it)
//   DMEM_BYPASS_EN undefined -> read-first: reads return the old contents
// ----------------------------------------------------------------------------
module dual_port_dmem
   import dmem_pkg::*;
#(
   parameter int AW    = dmem_pkg::AW,
   parameter int DW    = dmem_pkg::DW,
   parameter int DEPTH = dmem_pkg::DEPTH
) (
   input logic             clk,
   input logic             rst,
   dual_port_dmem_if.slave dm
);

   logic [DW-1:0] mem [DEPTH];

   logic          clear_we;
   logic [AW-1:0] clear_addr;
   logic          run;

   dmem_clear_seq #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_clear_seq (
      .clk        (clk),
      .rst        (rst),
      .clear_we   (clear_we),
      .clear_addr (clear_addr),
      .ready      (run)
   );

   logic          p0_we;
   logic          p1_we;
   logic          same_addr;
   logic          collide;
   logic [DW-1:0] p0_rd_next;
   logic [DW-1:0] p1_rd_next;

   // Pipe writes are dropped entirely until the clear sequence completes.
   assign p0_we     = run & dm.p0_DM_write_mem;
   assign p1_we     = run & dm.p1_DM_write_mem;
   assign same_addr = (dm.p0_DM_maddr == dm.p1_DM_maddr);
   assign collide   = p0_we & p1_we & same_addr;

   always_ff @(posedge clk) begin
      if (clear_we) begin
         mem[clear_addr] <= '0;
      end else begin
         // p1 is younger in program order, so its data survives a collision.
         if (p0_we && !collide) mem[dm.p0_DM_maddr] <= dm.p0_DM_wdata;
         if (p1_we)             mem[dm.p1_DM_maddr] <= dm.p1_DM_wdata;
      end
   end

`ifdef DMEM_BYPASS_EN
   // p1 is checked last so it overrides p0 when both write the read address.
   always_comb begin
      p0_rd_next = mem[dm.p0_DM_maddr];
      if (p0_we)              p0_rd_next = dm.p0_DM_wdata;
      if (p1_we && same_addr) p0_rd_next = dm.p1_DM_wdata;

      p1_rd_next = mem[dm.p1_DM_maddr];
      if (p0_we && same_addr) p1_rd_next = dm.p0_DM_wdata;
      if (p1_we)              p1_rd_next = dm.p1_DM_wdata;
   end
`else
   always_comb begin
      p0_rd_next = mem[dm.p0_DM_maddr];
      p1_rd_next = mem[dm.p1_DM_maddr];
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dm.p0_DM_rdata <= '0;
         dm.p1_DM_rdata <= '0;
         dm.DM_wcollide <= 1'b0;
      end else if (!run) begin
         dm.p0_DM_rdata <= '0;
         dm.p1_DM_rdata <= '0;
         dm.DM_wcollide <= 1'b0;
      end else begin
         dm.p0_DM_rdata <= p0_rd_next;
         dm.p1_DM_rdata <= p1_rd_next;
         dm.DM_wcollide <= collide;
      end
   end

   assign dm.DM_ready = run;

endmodule

// File: tb/tb_dual_port_dmem.sv
module tb_dual_port_dmem;
   import dmem_pkg::*;

`ifdef DMEM_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;

   dual_port_dmem_if #(.AW(AW), .DW(DW)) dm ();

   dual_port_dmem #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .dm  (dm)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: plain word array plus a count of edges since reset.
   dword_t mem_m [DEPTH];
   int     m_cnt = 0;

   typedef struct {
      logic          we0;
      logic [AW-1:0] a0;
      dword_t        d0;
      logic          we1;
      logic [AW-1:0] a1;
      dword_t        d1;
      dword_t        r0;
      dword_t        r1;
      logic          col;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic dword_t model_read(input logic [AW-1:0] ra,
                                         input logic we0, input logic [AW-1:0] a0, input dword_t d0,
                                         input logic we1, input logic [AW-1:0] a1, input dword_t d1);
      dword_t v;
      v = mem_m[ra];
      if (BYPASS && we0 && a0 == ra) v = d0;
      if (BYPASS && we1 && a1 == ra) v = d1;
      return v;
   endfunction

   // Drive one cycle of inputs, advance one edge, compare against the model.
   task automatic cycle(input logic we0, input logic [AW-1:0] a0, input dword_t d0,
                        input logic we1, input logic [AW-1:0] a1, input dword_t d1);
      dword_t e0, e1;
      logic   ec, er;
      dm.p0_DM_write_mem = we0;
      dm.p0_DM_maddr     = a0;
      dm.p0_DM_wdata     = d0;
      dm.p1_DM_write_mem = we1;
      dm.p1_DM_maddr     = a1;
      dm.p1_DM_wdata     = d1;
      if (m_cnt >= DEPTH) begin
         e0 = model_read(a0, we0, a0, d0, we1, a1, d1);
         e1 = model_read(a1, we0, a0, d0, we1, a1, d1);
         ec = we0 && we1 && (a0 == a1);
         if (we0) mem_m[a0] = d0;
         if (we1) mem_m[a1] = d1;
      end else begin
         e0 = '0;
         e1 = '0;
         ec = 1'b0;
         m_cnt++;
      end
      er = (m_cnt >= DEPTH);
      @(posedge clk);
      #1;
      check("p0_rdata", dm.p0_DM_rdata, e0);
      check("p1_rdata", dm.p1_DM_rdata, e1);
      check("wcollide", 16'(dm.DM_wcollide), 16'(ec));
      check("ready", 16'(dm.DM_ready), 16'(er));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_p0_rdata", dm.p0_DM_rdata, 16'h0000);
      check("rst_p1_rdata", dm.p1_DM_rdata, 16'h0000);
      check("rst_ready", 16'(dm.DM_ready), 16'h0000);
      check("rst_wcollide", 16'(dm.DM_wcollide), 16'h0000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_cnt = 0;
      foreach (mem_m[i]) mem_m[i] = '0;
      dm.p0_DM_write_mem = 1'b0;
      dm.p1_DM_write_mem = 1'b0;
   endtask

   // Clear phase with random pipe writes that must all be ignored; p0 also
   // writes FFFF to address 10 at clear cycle 3.
   task automatic run_clear(input int n);
      for (int i = 0; i < n; i++) begin
         if (i == 3)
            cycle(1'b1, AW'(10), 16'hFFFF, 1'b0, '0, '0);
         else
            cycle(1'($urandom), AW'($urandom_range(0, 15)), 16'($urandom),
                  1'($urandom), AW'($urandom_range(0, 15)), 16'($urandom));
      end
   endtask

   initial begin
      vecs[0] = '{1'b1, AW'(0),   16'h0002, 1'b1, AW'(1),   16'h0004,
                  BYPASS ? 16'h0002 : 16'h0000, BYPASS ? 16'h0004 : 16'h0000, 1'b0};
      vecs[1] = '{1'b0, AW'(1),   16'h0000, 1'b0, AW'(0),   16'h0000,
                  16'h0004, 16'h0002, 1'b0};
      vecs[2] = '{1'b1, AW'(300), 16'h1111, 1'b1, AW'(300), 16'h2222,
                  BYPASS ? 16'h2222 : 16'h0000, BYPASS ? 16'h2222 : 16'h0000, 1'b1};
      vecs[3] = '{1'b0, AW'(300), 16'h0000, 1'b0, AW'(300), 16'h0000,
                  16'h2222, 16'h2222, 1'b0};
      vecs[4] = '{1'b0, AW'(7),   16'h0000, 1'b1, AW'(7),   16'hAAAA,
                  BYPASS ? 16'hAAAA : 16'h0000, BYPASS ? 16'hAAAA : 16'h0000, 1'b0};
      vecs[5] = '{1'b1, AW'(7),   16'h5555, 1'b0, AW'(7),   16'h0000,
                  BYPASS ? 16'h5555 : 16'hAAAA, BYPASS ? 16'h5555 : 16'hAAAA, 1'b0};
      vecs[6] = '{1'b0, AW'(7),   16'h0000, 1'b0, AW'(7),   16'h0000,
                  16'h5555, 16'h5555, 1'b0};
      vecs[7] = '{1'b1, AW'(20),  16'h1234, 1'b1, AW'(21),  16'h5678,
                  BYPASS ? 16'h1234 : 16'h0000, BYPASS ? 16'h5678 : 16'h0000, 1'b0};
      vecs[8] = '{1'b0, AW'(20),  16'h0000, 1'b0, AW'(21),  16'h0000,
                  16'h1234, 16'h5678, 1'b0};

      dm.p0_DM_write_mem = 1'b0;
      dm.p0_DM_maddr     = '0;
      dm.p0_DM_wdata     = '0;
      dm.p1_DM_write_mem = 1'b0;
      dm.p1_DM_maddr     = '0;
      dm.p1_DM_wdata     = '0;
      #2;

      do_reset();
      run_clear(DEPTH);

      for (int i = 0; i < 9; i++) begin
         cycle(vecs[i].we0, vecs[i].a0, vecs[i].d0, vecs[i].we1, vecs[i].a1, vecs[i].d1);
         check($sformatf("vec%0d_p0", i), dm.p0_DM_rdata, vecs[i].r0);
         check($sformatf("vec%0d_p1", i), dm.p1_DM_rdata, vecs[i].r1);
         check($sformatf("vec%0d_col", i), 16'(dm.DM_wcollide), 16'(vecs[i].col));
      end

      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom), AW'($urandom_range(0, 15)), 16'($urandom),
               1'($urandom), AW'($urandom_range(0, 15)), 16'($urandom));
      end

      // Leave mem[5]=BEEF with rdata and wcollide non-zero, then reset.
      cycle(1'b1, AW'(5), 16'hBEEF, 1'b0, AW'(5), 16'h0000);
      cycle(1'b1, AW'(5), 16'hBEEF, 1'b1, AW'(5), 16'hBEEF);
      check("pre_rst_p0", dm.p0_DM_rdata, 16'hBEEF);
      check("pre_rst_col", 16'(dm.DM_wcollide), 16'h0001);
      do_reset();

      // Reset again partway through the clear; the sequence must restart.
      run_clear(200);
      do_reset();
      run_clear(DEPTH);
      check("ready_after_clear", 16'(dm.DM_ready), 16'h0001);

      cycle(1'b0, AW'(5), 16'h0000, 1'b0, AW'(10), 16'h0000);
      check("mem5_cleared", dm.p0_DM_rdata, 16'h0000);
      check("mem10_clear_write_ignored", dm.p1_DM_rdata, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
